// File: rtl/mix_engine_arbiter.sv
// Round-robin owner of the shared 8x32 mixing datapath: grants one requester at a time,
// then sequences one seed load plus ROUNDS passes of the 22-step stage schedule.
module mix_engine_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ROUNDS  = 1,
    localparam int IW = $clog2(NUM_REQ),
    localparam int PW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic               load_en,
    output logic               stage_en,
    output logic [2:0]         stage_sel,
    output logic [4:0]         step_idx,
    output logic [PW-1:0]      pass_idx,
    output logic [NUM_REQ-1:0] done,
    output logic [1:0]         state_dbg
);

    // Handshake: req[i] is a level held by requester i until done[i] pulses; gnt is one-hot
    // for the whole LOAD/RUN span, and req[owner] falling during LOAD/RUN aborts the job
    // without a done pulse. Requests of non-owners are only looked at in IDLE.
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t             state, state_d;
    logic [IW-1:0]      owner, owner_d, ptr, winner;
    logic               found;
    logic               owner_req, last_step;
    logic [NUM_REQ-1:0] onehot;
    logic [NUM_REQ-1:0] gnt_d, done_d;
    logic               busy_d, load_en_d, stage_en_d;
    logic [2:0]         sel_d;
    logic [4:0]         step_d;
    logic [PW-1:0]      pass_d;

    assign state_dbg = state;
    assign owner_req = req[owner];
    assign last_step = (step_idx == 5'd21) && (pass_idx == PW'(ROUNDS - 1));

    function automatic logic [2:0] stage_of(input logic [4:0] s);
        if      (s < 5'd2)  return 3'd0;
        else if (s < 5'd4)  return 3'd1;
        else if (s < 5'd6)  return 3'd2;
        else if (s < 5'd14) return 3'd3;
        else if (s < 5'd16) return 3'd4;
        else if (s < 5'd18) return 3'd5;
        else if (s < 5'd20) return 3'd6;
        else                return 3'd7;
    endfunction

    // First requester at or after ptr wins; if none, fall back to the lowest index below ptr.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (IW'(j) >= ptr)) begin
                found  = 1'b1;
                winner = IW'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j]) begin
                found  = 1'b1;
                winner = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_d;
            owner <= owner_d;
            if (state == S_IDLE && found)
                ptr <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + IW'(1);
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (found) state_d = S_LOAD;
            S_LOAD:  state_d = owner_req ? S_RUN : S_IDLE;
            S_RUN: begin
                if (!owner_req)     state_d = S_IDLE;
                else if (last_step) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        owner_d         = (state == S_IDLE && found) ? winner : owner;
        onehot          = '0;
        onehot[owner_d] = 1'b1;
        gnt_d      = (state_d == S_LOAD || state_d == S_RUN) ? onehot : '0;
        done_d     = (state_d == S_DONE) ? onehot : '0;
        busy_d     = (state_d != S_IDLE);
        load_en_d  = (state_d == S_LOAD);
        stage_en_d = (state_d == S_RUN);
        step_d     = '0;
        pass_d     = '0;
        // Entering RUN from LOAD starts at step 0 / pass 0; counters stay zero outside RUN.
        if (state_d == S_RUN && state == S_RUN) begin
            if (step_idx == 5'd21) begin
                step_d = '0;
                pass_d = pass_idx + PW'(1);
            end else begin
                step_d = step_idx + 5'd1;
                pass_d = pass_idx;
            end
        end
        sel_d = stage_en_d ? stage_of(step_d) : 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            busy      <= 1'b0;
            load_en   <= 1'b0;
            stage_en  <= 1'b0;
            stage_sel <= '0;
            step_idx  <= '0;
            pass_idx  <= '0;
            done      <= '0;
        end else begin
            gnt       <= gnt_d;
            busy      <= busy_d;
            load_en   <= load_en_d;
            stage_en  <= stage_en_d;
            stage_sel <= sel_d;
            step_idx  <= step_d;
            pass_idx  <= pass_d;
            done      <= done_d;
        end
    end

endmodule
